// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 receiver and scancode decoder; holds level key-down flags for key 1, key 2 and reset.
// Latency: byte, strobe and flags update 1 clk after the stop bit's falling edge is detected (edge seen 2-3 clk after the raw edge).
// Backpressure: none; the keyboard cannot be stalled and every byte is decoded as it arrives.
module ps2_key_decoder #(
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] KEY1_CODE      = 8'h16,
    parameter logic [7:0] KEY2_CODE      = 8'h1E,
    parameter logic [7:0] KEYR_CODE      = 8'h76
) (
    input  logic       clk,
    input  logic       iResetn,
    input  logic       iPs2Clk,
    input  logic       iPs2Dat,
    output logic       oOnePressed,
    output logic       oTwoPressed,
    output logic       oResetPressed,
    output logic [7:0] oByte,
    output logic       oByteValid,
    output logic       oFrameErr
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_t;

    rx_state_t       state, state_nxt;
    logic            ps2c_s1, ps2c_s2, ps2c_prev;
    logic            ps2d_s1, ps2d_s2;
    logic            fall;
    logic            d_bit;
    logic [7:0]      shreg;
    logic [2:0]      bit_cnt;
    logic            par_bit;
    logic [WD_W-1:0] wd_cnt;
    logic            timeout;
    logic            byte_good;
    logic            frame_bad;
    logic            brk_flag;
    logic            ext_flag;

    // Synchronisers reset to the idle-high line level so release from reset never fakes an edge.
    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            ps2c_s1   <= 1'b1;
            ps2c_s2   <= 1'b1;
            ps2c_prev <= 1'b1;
            ps2d_s1   <= 1'b1;
            ps2d_s2   <= 1'b1;
        end else begin
            ps2c_s1   <= iPs2Clk;
            ps2c_s2   <= ps2c_s1;
            ps2c_prev <= ps2c_s2;
            ps2d_s1   <= iPs2Dat;
            ps2d_s2   <= ps2d_s1;
        end
    end

    assign fall    = ps2c_prev & ~ps2c_s2;
    assign d_bit   = ps2d_s2;
    assign timeout = (state != S_IDLE) && !fall && (wd_cnt >= WD_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        byte_good = 1'b0;
        frame_bad = 1'b0;
        if (fall) begin
            case (state)
                S_IDLE: begin
                    if (!d_bit) begin
                        state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_cnt == 3'd7) begin
                        state_nxt = S_PARITY;
                    end
                end
                S_PARITY: begin
                    state_nxt = S_STOP;
                end
                S_STOP: begin
                    state_nxt = S_IDLE;
                    if (d_bit && ((^shreg ^ par_bit) == 1'b1)) begin
                        byte_good = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end else if (timeout) begin
            state_nxt = S_IDLE;
            frame_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            shreg   <= 8'h00;
            bit_cnt <= 3'd0;
            par_bit <= 1'b0;
            wd_cnt  <= '0;
        end else begin
            if (fall || state == S_IDLE) begin
                wd_cnt <= '0;
            end else if (!timeout) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (fall) begin
                case (state)
                    S_IDLE:   bit_cnt <= 3'd0;
                    S_DATA: begin
                        shreg   <= {d_bit, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    S_PARITY: par_bit <= d_bit;
                    default:  ;
                endcase
            end
        end
    end

    // Prefix flags live only until the next non-prefix byte, error or timeout.
    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            oByte         <= 8'h00;
            oByteValid    <= 1'b0;
            oFrameErr     <= 1'b0;
            oOnePressed   <= 1'b0;
            oTwoPressed   <= 1'b0;
            oResetPressed <= 1'b0;
            brk_flag      <= 1'b0;
            ext_flag      <= 1'b0;
        end else begin
            oByteValid <= byte_good;
            oFrameErr  <= frame_bad;
            if (frame_bad) begin
                brk_flag <= 1'b0;
                ext_flag <= 1'b0;
            end else if (byte_good) begin
                oByte <= shreg;
                if (shreg == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else if (shreg == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else begin
                    brk_flag <= 1'b0;
                    ext_flag <= 1'b0;
                    if (!ext_flag) begin
                        if (shreg == KEY1_CODE) oOnePressed   <= ~brk_flag;
                        if (shreg == KEY2_CODE) oTwoPressed   <= ~brk_flag;
                        if (shreg == KEYR_CODE) oResetPressed <= ~brk_flag;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: table of whole frames plus hand sequences for timeout, spurious edge and mid-frame reset.
module tb_ps2_key_decoder;

    localparam int TMO  = 400;
    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       iResetn = 1'b0;
    logic       iPs2Clk = 1'b1;
    logic       iPs2Dat = 1'b1;
    logic       oOnePressed, oTwoPressed, oResetPressed;
    logic [7:0] oByte;
    logic       oByteValid, oFrameErr;

    int checks = 0;
    int failures = 0;
    int vld_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [7:0] dat;
        logic       bad_par;
        logic       stop;
        logic       e_one;
        logic       e_two;
        logic       e_rst;
        logic [7:0] e_byte;
        int         e_vld;
        int         e_err;
    } vec_t;

    vec_t tbl[$];

    ps2_key_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .iResetn      (iResetn),
        .iPs2Clk      (iPs2Clk),
        .iPs2Dat      (iPs2Dat),
        .oOnePressed  (oOnePressed),
        .oTwoPressed  (oTwoPressed),
        .oResetPressed(oResetPressed),
        .oByte        (oByte),
        .oByteValid   (oByteValid),
        .oFrameErr    (oFrameErr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (oByteValid) vld_cnt <= vld_cnt + 1;
        if (oFrameErr)  err_cnt <= err_cnt + 1;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic settle(input int n);
        iPs2Clk = 1'b1;
        iPs2Dat = 1'b1;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        iPs2Dat = b;
        repeat (HALF) @(negedge clk);
        iPs2Clk = 1'b0;
        repeat (HALF) @(negedge clk);
        iPs2Clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
        logic par;
        par = ~(^d) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
        settle(10);
    endtask

    task automatic check_outs(input string tag, input logic e1, input logic e2, input logic er,
                              input logic [7:0] eb);
        check({tag, "_one"},  int'(oOnePressed),   int'(e1));
        check({tag, "_two"},  int'(oTwoPressed),   int'(e2));
        check({tag, "_rst"},  int'(oResetPressed), int'(er));
        check({tag, "_byte"}, int'(oByte),         int'(eb));
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic bp, input logic st,
                                input logic e1, input logic e2, input logic er,
                                input logic [7:0] eb, input int ev, input int ee);
        vec_t v;
        v.dat = d; v.bad_par = bp; v.stop = st;
        v.e_one = e1; v.e_two = e2; v.e_rst = er;
        v.e_byte = eb; v.e_vld = ev; v.e_err = ee;
        return v;
    endfunction

    initial begin
        int v0, e0;

        //                dat   bp  st  one two rst byte  vld err
        tbl.push_back(mk(8'h16, 0, 1,  1,  0,  0, 8'h16, 1, 0));
        tbl.push_back(mk(8'hF0, 0, 1,  1,  0,  0, 8'hF0, 1, 0));
        tbl.push_back(mk(8'h16, 0, 1,  0,  0,  0, 8'h16, 1, 0));
        tbl.push_back(mk(8'h1E, 1, 1,  0,  0,  0, 8'h16, 0, 1));
        tbl.push_back(mk(8'hE0, 0, 1,  0,  0,  0, 8'hE0, 1, 0));
        tbl.push_back(mk(8'h16, 0, 1,  0,  0,  0, 8'h16, 1, 0));
        tbl.push_back(mk(8'h16, 0, 1,  1,  0,  0, 8'h16, 1, 0));
        tbl.push_back(mk(8'h1E, 0, 1,  1,  1,  0, 8'h1E, 1, 0));
        tbl.push_back(mk(8'h1E, 0, 1,  1,  1,  0, 8'h1E, 1, 0));
        tbl.push_back(mk(8'hF0, 0, 1,  1,  1,  0, 8'hF0, 1, 0));
        tbl.push_back(mk(8'h1E, 0, 1,  1,  0,  0, 8'h1E, 1, 0));
        tbl.push_back(mk(8'hF0, 0, 1,  1,  0,  0, 8'hF0, 1, 0));
        tbl.push_back(mk(8'h76, 0, 1,  1,  0,  0, 8'h76, 1, 0));
        tbl.push_back(mk(8'hAA, 0, 1,  1,  0,  0, 8'hAA, 1, 0));
        tbl.push_back(mk(8'h1E, 0, 0,  1,  0,  0, 8'hAA, 0, 1));
        tbl.push_back(mk(8'hE0, 0, 1,  1,  0,  0, 8'hE0, 1, 0));
        tbl.push_back(mk(8'hF0, 0, 1,  1,  0,  0, 8'hF0, 1, 0));
        tbl.push_back(mk(8'h16, 0, 1,  1,  0,  0, 8'h16, 1, 0));
        tbl.push_back(mk(8'h76, 0, 1,  1,  0,  1, 8'h76, 1, 0));
        tbl.push_back(mk(8'hF0, 0, 1,  1,  0,  1, 8'hF0, 1, 0));
        tbl.push_back(mk(8'h1E, 1, 1,  1,  0,  1, 8'hF0, 0, 1));
        tbl.push_back(mk(8'h1E, 0, 1,  1,  1,  1, 8'h1E, 1, 0));
        tbl.push_back(mk(8'hF0, 0, 1,  1,  1,  1, 8'hF0, 1, 0));
        tbl.push_back(mk(8'h76, 0, 1,  1,  1,  0, 8'h76, 1, 0));

        repeat (3) @(negedge clk);
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 8'h00);
        check("reset_vld", int'(oByteValid), 0);
        check("reset_err", int'(oFrameErr), 0);
        @(negedge clk);
        iResetn = 1'b1;
        settle(5);

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            v0 = vld_cnt;
            e0 = err_cnt;
            send_frame(tbl[i].dat, tbl[i].bad_par, tbl[i].stop);
            check_outs(tag, tbl[i].e_one, tbl[i].e_two, tbl[i].e_rst, tbl[i].e_byte);
            check({tag, "_vld"}, vld_cnt - v0, tbl[i].e_vld);
            check({tag, "_err"}, err_cnt - e0, tbl[i].e_err);
        end

        // A falling edge with data high while idle is not a start bit.
        v0 = vld_cnt;
        e0 = err_cnt;
        send_bit(1'b1);
        settle(10);
        check("spur_vld", vld_cnt - v0, 0);
        check("spur_err", err_cnt - e0, 0);

        // Break prefix, then a frame abandoned after 4 data bits; the watchdog must drop the prefix too.
        send_frame(8'hF0, 1'b0, 1'b1);
        v0 = vld_cnt;
        e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        settle(TMO + 10);
        check("tmo_err", err_cnt - e0, 1);
        check("tmo_vld", vld_cnt - v0, 0);
        check_outs("tmo_hold", 1'b1, 1'b1, 1'b0, 8'hF0);
        send_frame(8'h76, 1'b0, 1'b1);
        check_outs("tmo_next", 1'b1, 1'b1, 1'b1, 8'h76);

        // Asynchronous reset in the middle of a frame.
        e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        @(negedge clk);
        #2;
        iResetn = 1'b0;
        #1;
        check_outs("arst", 1'b0, 1'b0, 1'b0, 8'h00);
        check("arst_vld", int'(oByteValid), 0);
        check("arst_err", int'(oFrameErr), 0);
        settle(4);
        iResetn = 1'b1;
        settle(TMO + 10);
        check("arst_silent", err_cnt - e0, 0);
        v0 = vld_cnt;
        send_frame(8'h1E, 1'b0, 1'b1);
        check_outs("arst_next", 1'b0, 1'b1, 1'b0, 8'h1E);
        check("arst_next_vld", vld_cnt - v0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
